// File: rtl/fft8_dit_engine.sv
// 8-point radix-2 DIT FFT: bit-reversed load, 12 in-place butterflies, natural-order output.
// Define FFT8_IFFT_EN to add the 'inverse' port (conjugate twiddles, no 1/8 scaling).
module fft8_dit_engine #(
  parameter int DATA_W   = 12,
  parameter int OUT_W    = 15,
  parameter int TW_SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic [2:0]        tw_index,
  input  logic [11:0]       tw_re,
  input  logic [11:0]       tw_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_re,
  output logic [OUT_W-1:0]  out_im,
  output logic [2:0]        out_bin,
  output logic              out_last,
  output logic              busy
`ifdef FFT8_IFFT_EN
  ,
  input  logic              inverse
`endif
);

  localparam int PROD_W = OUT_W + 12;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       stage_q, stage_d;
  logic [1:0]       bfly_q, bfly_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [2:0]       out_bin_q, out_bin_d;
  logic [OUT_W-1:0] out_re_q, out_re_d;
  logic [OUT_W-1:0] out_im_q, out_im_d;

  logic [OUT_W-1:0] mem_re_q [8];
  logic [OUT_W-1:0] mem_im_q [8];

  logic [2:0] top_idx, bot_idx, tw_k, tw_sel, ld_addr, nxt_bin;
  logic [OUT_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic [OUT_W-1:0] top_re, top_im, bot_re, bot_im;
  logic signed [PROD_W-1:0] br_x, bi_x, twr_x, twi_x, prod_re, prod_im;

  assign in_ready  = rst_n && (state_q == S_LOAD);
  assign busy      = (state_q == S_CALC) || (state_q == S_OUT);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_bin   = out_bin_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign ld_addr   = {cnt_q[0], cnt_q[1], cnt_q[2]};

  // Butterfly pair and twiddle exponent for (stage, butterfly); bot always sits one span above top.
  always_comb begin
    top_idx = 3'd0;
    tw_k    = 3'd0;
    case (stage_q)
      2'd0:    top_idx = {bfly_q, 1'b0};
      2'd1:    begin top_idx = {bfly_q[1], 1'b0, bfly_q[0]}; tw_k = {1'b0, bfly_q[0], 1'b0}; end
      2'd2:    begin top_idx = {1'b0, bfly_q}; tw_k = {1'b0, bfly_q}; end
      default: ;
    endcase
    bot_idx = top_idx | (3'd1 << stage_q);
  end

`ifdef FFT8_IFFT_EN
  logic inv_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                     inv_q <= 1'b0;
    else if (in_valid && in_ready && cnt_q == 3'd0) inv_q <= inverse;
  end
  assign tw_sel = inv_q ? 3'd0 - tw_k : tw_k;
`else
  assign tw_sel = tw_k;
`endif

  assign tw_index = (state_q == S_CALC) ? tw_sel : 3'd0;

  assign a_re  = mem_re_q[top_idx];
  assign a_im  = mem_im_q[top_idx];
  assign b_re  = mem_re_q[bot_idx];
  assign b_im  = mem_im_q[bot_idx];
  assign br_x  = PROD_W'($signed(b_re));
  assign bi_x  = PROD_W'($signed(b_im));
  assign twr_x = PROD_W'($signed(tw_re));
  assign twi_x = PROD_W'($signed(tw_im));

  assign prod_re = br_x * twr_x - bi_x * twi_x;
  assign prod_im = br_x * twi_x + bi_x * twr_x;
  assign t_re    = OUT_W'(prod_re >>> TW_SHIFT);
  assign t_im    = OUT_W'(prod_im >>> TW_SHIFT);
  assign top_re  = a_re + t_re;
  assign top_im  = a_im + t_im;
  assign bot_re  = a_re - t_re;
  assign bot_im  = a_im - t_im;

  assign nxt_bin = out_valid_q ? out_bin_q + 3'd1 : 3'd0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    bfly_d      = bfly_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_bin_d   = out_bin_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    case (state_q)
      S_LOAD: if (in_valid) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_CALC;
      end
      S_CALC: begin
        bfly_d = bfly_q + 2'd1;
        if (bfly_q == 2'd3) begin
          stage_d = stage_q + 2'd1;
          if (stage_q == 2'd2) begin
            stage_d = 2'd0;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        // First OUT cycle prefetches bin 0; afterwards each handshake fetches the next bin.
        if (out_valid_q && out_ready && out_bin_q == 3'd7) begin
          state_d     = S_LOAD;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_bin_d   = 3'd0;
        end else if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_bin_d   = nxt_bin;
          out_last_d  = (nxt_bin == 3'd7);
          out_re_d    = mem_re_q[nxt_bin];
          out_im_d    = mem_im_q[nxt_bin];
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= 3'd0;
      stage_q     <= 2'd0;
      bfly_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bin_q   <= 3'd0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bin_q   <= out_bin_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // NOTE: the sample buffer is deliberately not reset; every frame overwrites all 8 entries before use.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      mem_re_q[ld_addr] <= OUT_W'($signed(in_re));
      mem_im_q[ld_addr] <= OUT_W'($signed(in_im));
    end else if (rst_n && state_q == S_CALC) begin
      mem_re_q[top_idx] <= top_re;
      mem_im_q[top_idx] <= top_im;
      mem_re_q[bot_idx] <= bot_re;
      mem_im_q[bot_idx] <= bot_im;
    end
  end

endmodule

// File: tb/tb_fft8_dit_engine.sv
// Directed bench for fft8_dit_engine with a behavioural twiddle table (scale 127).
// Expected bins are bit-exact: the 127/128 twiddle gain plus floor truncation leaves small residues.
module tb_fft8_dit_engine;
  localparam int DATA_W = 12;
  localparam int OUT_W  = 15;
  localparam int TMO    = 200;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [DATA_W-1:0] in_re, in_im;
  logic [2:0] tw_index, out_bin;
  logic signed [11:0] tw_re, tw_im;
  logic [OUT_W-1:0] out_re, out_im;
`ifdef FFT8_IFFT_EN
  logic inverse;
`endif

  int checks = 0;
  int passes = 0;
  logic [OUT_W-1:0] got_re [8];
  logic [OUT_W-1:0] got_im [8];
  logic [2:0]       got_bin [8];
  logic             got_last [8];
  int               got_n;

  fft8_dit_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .tw_index(tw_index), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_bin(out_bin), .out_last(out_last), .busy(busy)
`ifdef FFT8_IFFT_EN
    , .inverse(inverse)
`endif
  );

  always #5 clk = ~clk;

  // Forward twiddle table W^k = e^(-j2*pi*k/8), rounded at scale 127.
  always_comb begin
    case (tw_index)
      3'd0:    begin tw_re =  12'sd127; tw_im =  12'sd0;   end
      3'd1:    begin tw_re =  12'sd90;  tw_im = -12'sd90;  end
      3'd2:    begin tw_re =  12'sd0;   tw_im = -12'sd127; end
      3'd3:    begin tw_re = -12'sd90;  tw_im = -12'sd90;  end
      3'd4:    begin tw_re = -12'sd127; tw_im =  12'sd0;   end
      3'd5:    begin tw_re = -12'sd90;  tw_im =  12'sd90;  end
      3'd6:    begin tw_re =  12'sd0;   tw_im =  12'sd127; end
      default: begin tw_re =  12'sd90;  tw_im =  12'sd90;  end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int re [8], input int first);
    int w;
    for (int n = first; n < 8; n++) begin
      in_valid = 1'b1;
      in_re    = DATA_W'(re[n]);
      in_im    = '0;
      w = 0;
      while (!in_ready && w < TMO) begin tick(); w++; end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_got();
    got_n = 0;
    for (int k = 0; k < 8; k++) begin
      got_re[k] = 'x; got_im[k] = 'x; got_bin[k] = 'x; got_last[k] = 1'bx;
    end
  endtask

  task automatic record_bin();
    got_re[got_n]   = out_re;
    got_im[got_n]   = out_im;
    got_bin[got_n]  = out_bin;
    got_last[got_n] = out_last;
    got_n++;
  endtask

  task automatic collect_frame();
    int w;
    w = 0;
    clear_got();
    out_ready = 1'b1;
    while (got_n < 8 && w < TMO) begin
      if (out_valid && out_ready) record_bin();
      tick();
      w++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, expected 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b, expected 0", out_last); else passes++;
    checks++; if (out_bin !== 3'd0) $display("FAIL reset_out_bin: got %0d, expected 0", out_bin); else passes++;
    checks++; if (out_re !== '0 || out_im !== '0) $display("FAIL reset_out_data: got %0d/%0d, expected 0/0", out_re, out_im); else passes++;
    checks++; if (tw_index !== 3'd0) $display("FAIL reset_tw_index: got %0d, expected 0", tw_index); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, expected 1", in_ready); else passes++;
  endtask

  task automatic test_impulse();
    int frm [8];
    frm = '{100, 0, 0, 0, 0, 0, 0, 0};
    send_frame(frm, 0);
    collect_frame();
    checks++; if (got_n != 8) $display("FAIL impulse_count: got %0d bins, expected 8", got_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(100) || got_im[k] !== '0 || got_bin[k] !== 3'(k) || got_last[k] !== (k == 7))
        $display("FAIL impulse_bin%0d: got re=%0d im=%0d bin=%0d last=%b, expected re=100 im=0 bin=%0d last=%b",
                 k, $signed(got_re[k]), $signed(got_im[k]), got_bin[k], got_last[k], k, k == 7);
      else passes++;
    end
  endtask

  task automatic test_dc();
    int frm [8];
    int er [8];
    int ei [8];
    int n;
    frm = '{100, 100, 100, 100, 100, 100, 100, 100};
    er  = '{788, 1, 2, 1, 4, 1, 2, 1};
    ei  = '{0, -3, -2, -1, 0, 1, 2, 3};
    send_frame(frm, 0);
    n = 0;
    while (!out_valid && n < TMO) begin tick(); n++; end
    checks++; if (n != 13) $display("FAIL dc_latency: got %0d edges, expected 13", n); else passes++;
    collect_frame();
    checks++; if (got_n != 8) $display("FAIL dc_count: got %0d bins, expected 8", got_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(er[k]) || got_im[k] !== 15'(ei[k]) || got_bin[k] !== 3'(k) || got_last[k] !== (k == 7))
        $display("FAIL dc_bin%0d: got re=%0d im=%0d bin=%0d last=%b, expected re=%0d im=%0d bin=%0d last=%b",
                 k, $signed(got_re[k]), $signed(got_im[k]), got_bin[k], got_last[k], er[k], ei[k], k, k == 7);
      else passes++;
    end
  endtask

  task automatic test_shifted_impulse();
    int frm [8];
    int er [8];
    int ei [8];
    int etw [12];
    frm = '{0, 64, 0, 0, 0, 0, 0, 0};
    er  = '{63, 45, 0, -45, -63, -45, 0, 45};
    ei  = '{0, -45, -64, -45, 0, 45, 64, 45};
    etw = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    in_valid = 1'b0;
    send_frame(frm, 0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL calc_flags: got busy=%b in_ready=%b, expected 1/0", busy, in_ready);
    else passes++;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tw_index !== 3'(etw[i])) $display("FAIL tw_index_%0d: got %0d, expected %0d", i, tw_index, etw[i]);
      else passes++;
      tick();
    end
    collect_frame();
    checks++; if (got_n != 8) $display("FAIL shift_count: got %0d bins, expected 8", got_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(er[k]) || got_im[k] !== 15'(ei[k]) || got_bin[k] !== 3'(k))
        $display("FAIL shift_bin%0d: got re=%0d im=%0d bin=%0d, expected re=%0d im=%0d bin=%0d",
                 k, $signed(got_re[k]), $signed(got_im[k]), got_bin[k], er[k], ei[k], k);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int frm [8];
    int er [8];
    int ei [8];
    int w;
    logic stalled;
    frm = '{0, 64, 0, 0, 0, 0, 0, 0};
    er  = '{63, 45, 0, -45, -63, -45, 0, 45};
    ei  = '{0, -45, -64, -45, 0, 45, 64, 45};
    send_frame(frm, 0);
    clear_got();
    w = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    while (got_n < 8 && w < TMO) begin
      if (out_valid && out_bin == 3'd3 && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_bin !== 3'd3 || out_re !== 15'(er[3]) || out_im !== 15'(ei[3]))
            $display("FAIL stall_hold_%0d: got valid=%b bin=%0d re=%0d im=%0d, expected 1/3/%0d/%0d",
                     c, out_valid, out_bin, $signed(out_re), $signed(out_im), er[3], ei[3]);
          else passes++;
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) record_bin();
      tick();
      w++;
    end
    checks++; if (got_n != 8) $display("FAIL stall_count: got %0d bins, expected 8", got_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(er[k]) || got_im[k] !== 15'(ei[k]) || got_bin[k] !== 3'(k))
        $display("FAIL stall_bin%0d: got re=%0d im=%0d bin=%0d, expected re=%0d im=%0d bin=%0d",
                 k, $signed(got_re[k]), $signed(got_im[k]), got_bin[k], er[k], ei[k], k);
      else passes++;
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL stall_extra_bin: got out_valid=%b, expected 0", out_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    int fa [8];
    int fb [8];
    int er [8];
    int ei [8];
    int w;
    int early;
    fa = '{100, 0, 0, 0, 0, 0, 0, 0};
    fb = '{0, 64, 0, 0, 0, 0, 0, 0};
    er = '{63, 45, 0, -45, -63, -45, 0, 45};
    ei = '{0, -45, -64, -45, 0, 45, 64, 45};
    send_frame(fa, 0);
    in_valid = 1'b1;
    in_re    = DATA_W'(fb[0]);
    clear_got();
    w = 0;
    early = 0;
    out_ready = 1'b1;
    while (got_n < 8 && w < TMO) begin
      if (in_ready) early++;
      if (out_valid) record_bin();
      tick();
      w++;
    end
    checks++; if (early != 0) $display("FAIL b2b_early_accept: got %0d ready cycles, expected 0", early); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_last: got %b, expected 1", in_ready); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(100) || got_im[k] !== '0)
        $display("FAIL b2b_a_bin%0d: got re=%0d im=%0d, expected re=100 im=0", k, $signed(got_re[k]), $signed(got_im[k]));
      else passes++;
    end
    tick();
    send_frame(fb, 1);
    collect_frame();
    checks++; if (got_n != 8) $display("FAIL b2b_b_count: got %0d bins, expected 8", got_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(er[k]) || got_im[k] !== 15'(ei[k]))
        $display("FAIL b2b_b_bin%0d: got re=%0d im=%0d, expected re=%0d im=%0d",
                 k, $signed(got_re[k]), $signed(got_im[k]), er[k], ei[k]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_calc();
    int fd [8];
    int fi [8];
    fd = '{100, 100, 100, 100, 100, 100, 100, 100};
    fi = '{100, 0, 0, 0, 0, 0, 0, 0};
    send_frame(fd, 0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || tw_index !== 3'd0)
      $display("FAIL midreset_state: got valid=%b busy=%b ready=%b tw=%0d, expected 0/0/0/0",
               out_valid, busy, in_ready, tw_index);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL midreset_ready: got %b, expected 1", in_ready); else passes++;
    send_frame(fi, 0);
    collect_frame();
    checks++; if (got_n != 8) $display("FAIL midreset_count: got %0d bins, expected 8", got_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(100) || got_im[k] !== '0 || got_last[k] !== (k == 7))
        $display("FAIL midreset_bin%0d: got re=%0d im=%0d last=%b, expected re=100 im=0 last=%b",
                 k, $signed(got_re[k]), $signed(got_im[k]), got_last[k], k == 7);
      else passes++;
    end
  endtask

`ifdef FFT8_IFFT_EN
  task automatic test_inverse();
    int frm [8];
    int er [8];
    int ei [8];
    frm = '{0, 64, 0, 0, 0, 0, 0, 0};
    er  = '{63, 45, 0, -45, -63, -45, 0, 45};
    ei  = '{0, 45, 63, 45, 0, -45, -63, -45};
    inverse = 1'b1;
    send_frame(frm, 0);
    inverse = 1'b0;
    collect_frame();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_re[k] !== 15'(er[k]) || got_im[k] !== 15'(ei[k]))
        $display("FAIL inv_bin%0d: got re=%0d im=%0d, expected re=%0d im=%0d",
                 k, $signed(got_re[k]), $signed(got_im[k]), er[k], ei[k]);
      else passes++;
    end
    // Forward transform of x[0]=10 is 10 in every bin; invert that spectrum.
    frm = '{10, 10, 10, 10, 10, 10, 10, 10};
    inverse = 1'b1;
    send_frame(frm, 0);
    inverse = 1'b0;
    collect_frame();
    checks++;
    if (got_re[0] !== 15'(73) || got_im[0] !== '0)
      $display("FAIL inv_roundtrip_n0: got re=%0d im=%0d, expected re=73 im=0", $signed(got_re[0]), $signed(got_im[0]));
    else passes++;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
`ifdef FFT8_IFFT_EN
    inverse   = 1'b0;
`endif
    test_reset();
    test_impulse();
    test_dc();
    test_shifted_impulse();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef FFT8_IFFT_EN
    test_inverse();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passes, checks);
    $fatal(1);
  end

endmodule
